keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
Scans the 4x4 matrix keypad and debounces it. Emits a clean key code with a one-cycle press strobe and a held-level flag. Sits directly upstream of the dot-matrix display stage, which latches key_code when key_valid is high. It replaces raw single-sample decoding with a multi-frame stability filter and rejects multi-key presses.

Parameters:
SCAN_DIV, 25000, clk_in cycles each row is driven (dwell); legal range >= 4
DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a press or a release; legal range >= 2

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
keypad_col  input  4  raw column sense lines, active-low, asynchronous to clk_in
keypad_row  output  4  row drive, one-hot-low
key_code  output  4  last accepted key code
key_valid  output  1  one-cycle strobe on accepted press
key_held  output  1  high from accepted press until accepted release

Behaviour:
- Reset: clk_in is the clock; reset is asynchronous and active-low. While reset is low:
  - keypad_row = 4'b1110; key_code = 0; key_valid = 0; key_held = 0.
  - Synchronizer flops = 4'b1111; dwell counter = 0; row index = 0; stable count = 0; previous result = NONE.
- Synchronization: keypad_col passes through 2 flops before any use.
- Row scan:
  - Row sequence is 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - The dwell counter counts 0..SCAN_DIV-1. On count SCAN_DIV-1, the synchronized columns are sampled for the current row and the row advances on the next edge.
  - One frame = 4*SCAN_DIV cycles.
- Key map, as {row, col}:
  - row 1110: cols 1110/1101/1011/0111 = 7/4/1/0
  - row 1101: 8/5/2/A
  - row 1011: 9/6/3/B
  - row 0111: C/D/E/F
- Frame accumulation:
  - The per-frame accumulator holds a count of active (low) cols seen, saturating at 2, and the code of the last active key.
  - Any row sample with two or more cols low counts as 2.
- Frame result, evaluated on the row-3 sample cycle:
  - NONE: count 0.
  - SINGLE(code): count 1.
  - MULTI: count 2.
  - The accumulator clears for the next frame in the same cycle.
- Debounce:
  - If the frame result equals the previous result (code included for SINGLE), stable count = min(stable + 1, DEBOUNCE_SCANS).
  - Otherwise stable count = 1.
  - The previous result is updated every frame.
- Press acceptance: on the frame-end cycle where stable count becomes DEBOUNCE_SCANS, the result is SINGLE, and key_held = 0:
  - key_code <= code, key_held <= 1, key_valid = 1 for exactly one cycle (registered, asserted the cycle after frame end).
- Release acceptance: when stable count becomes DEBOUNCE_SCANS with result NONE, key_held <= 0. No strobe.
- Holding the key: a held key never re-strobes.
- Direct key change: a change from one SINGLE code to another, with no NONE frames between, produces no strobe until NONE has been accepted.
- MULTI: never strobes; key_held and key_code are unchanged.
- key_code holds its value indefinitely after release.
- Reset asserted mid-frame: all state returns to reset values immediately, and scanning restarts at row 1110 with count 0 after reset is released.
- key_valid and key_held are never high on the same edge that key_held falls.

Decomposition:
- Shared package keypad_pkg:
  - row drive constants ROW0..ROW3
  - frame-result enum FR_NONE / FR_SINGLE / FR_MULTI
  - key-map function (row index, col) -> code
- One sub-module: keypad_col_sync, a 4-bit 2-flop synchronizer with async active-low reset to 1111.

Test Plan:
Bench uses SCAN_DIV=8 and DEBOUNCE_SCANS=3, giving a 32-cycle frame.
1. Reset, then idle with cols = 1111 -> keypad_row cycles 1110/1101/1011/0111, each for 8 cycles; key_valid never asserts; key_code = 0.
2. Hold key 5 (cols = 1101 whenever row = 1101) for 10 frames -> exactly one key_valid pulse, key_code = 4'h5, key_held = 1. Release -> key_held falls 3 frames later.
3. Key 5 toggling every frame for 6 frames, then stable -> no strobe during the toggling; one strobe in the 3rd stable frame.
4. Keys 1 and F pressed together for 6 frames -> no strobe; key_code keeps its prior value.
5. Accept key A, move directly to key 3 with no release -> no second strobe. Then release for 3 frames and press 3 -> strobe with key_code = 4'h3.
6. Reset low mid-dwell while key_held = 1 -> key_held = 0, key_code = 0, keypad_row = 1110 immediately. After release, a held key requires 3 full frames before its strobe.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, types and key map for the 4x4 keypad scanner.
package keypad_pkg;

   localparam logic [3:0] ROW0 = 4'b1110;
   localparam logic [3:0] ROW1 = 4'b1101;
   localparam logic [3:0] ROW2 = 4'b1011;
   localparam logic [3:0] ROW3 = 4'b0111;

   typedef enum logic [1:0] {
      FR_NONE,
      FR_SINGLE,
      FR_MULTI
   } frame_result_e;

   // Code is kept at zero for NONE/MULTI so whole-struct compares work.
   typedef struct packed {
      frame_result_e kind;
      logic [3:0]    code;
   } frame_res_t;

   function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
      logic [3:0] drive;
      unique case (row_idx)
         2'd0:    drive = ROW0;
         2'd1:    drive = ROW1;
         2'd2:    drive = ROW2;
         default: drive = ROW3;
      endcase
      return drive;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] code;
      unique case ({row_idx, col_idx})
         4'b00_00: code = 4'h7;
         4'b00_01: code = 4'h4;
         4'b00_10: code = 4'h1;
         4'b00_11: code = 4'h0;
         4'b01_00: code = 4'h8;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h2;
         4'b01_11: code = 4'hA;
         4'b10_00: code = 4'h9;
         4'b10_01: code = 4'h6;
         4'b10_10: code = 4'h3;
         4'b10_11: code = 4'hB;
         4'b11_00: code = 4'hC;
         4'b11_01: code = 4'hD;
         4'b11_10: code = 4'hE;
         default:  code = 4'hF;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the active-low keypad column sense lines.
module keypad_col_sync (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [3:0] col_raw,
   output logic [3:0] col_sync
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   // Reset to all-high: no key seen until real samples arrive.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= col_raw;
         sync_q <= meta_q;
      end
   end

   assign col_sync = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with per-frame multi-key rejection and multi-frame debounce.
module keypad_scan_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 25000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [3:0] keypad_col,
   output logic [3:0] keypad_row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DivW  = $clog2(SCAN_DIV);
   localparam int unsigned StabW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DivW-1:0]  DwellLast = DivW'(SCAN_DIV - 1);
   localparam logic [StabW-1:0] StabMax   = StabW'(DEBOUNCE_SCANS);

   logic [3:0]       col_sync;
   logic [DivW-1:0]  dwell_q, dwell_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [1:0]       acc_cnt_q, acc_cnt_d;
   logic [3:0]       acc_code_q, acc_code_d;
   frame_res_t       prev_q, prev_d;
   logic [StabW-1:0] stable_q, stable_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_held_q, key_held_d;
   logic             key_valid_q, key_valid_d;

   logic             sample;
   logic             frame_end;
   logic [3:0]       col_low;
   logic [2:0]       n_low;
   logic [1:0]       low_idx;
   logic [1:0]       row_cnt;
   logic [2:0]       acc_sum;
   logic [1:0]       merged_cnt;
   logic [3:0]       merged_code;
   frame_res_t       res;
   logic [StabW-1:0] stable_inc;
   logic [StabW-1:0] stable_next;
   logic             stable_full;

   keypad_col_sync u_col_sync (
      .clk_in   (clk_in),
      .reset    (reset),
      .col_raw  (keypad_col),
      .col_sync (col_sync)
   );

   assign sample    = (dwell_q == DwellLast);
   assign frame_end = sample && (row_idx_q == 2'd3);

   // Classify the current row sample.
   always_comb begin
      col_low = ~col_sync;
      n_low   = {2'b0, col_low[0]} + {2'b0, col_low[1]} + {2'b0, col_low[2]} + {2'b0, col_low[3]};
      low_idx = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (col_low[c]) begin
            low_idx = 2'(c);
         end
      end
      row_cnt = (n_low >= 3'd2) ? 2'd2 : n_low[1:0];
   end

   // Fold the sample into the frame accumulator (saturating at 2 = MULTI).
   always_comb begin
      acc_sum     = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
      merged_cnt  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
      merged_code = (n_low == 3'd1) ? key_map(row_idx_q, low_idx) : acc_code_q;
   end

   always_comb begin
      res.kind = FR_NONE;
      res.code = 4'h0;
      unique case (merged_cnt)
         2'd0: res.kind = FR_NONE;
         2'd1: begin
            res.kind = FR_SINGLE;
            res.code = merged_code;
         end
         default: res.kind = FR_MULTI;
      endcase
   end

   always_comb begin
      stable_inc  = (stable_q == StabMax) ? stable_q : stable_q + StabW'(1);
      stable_next = (res == prev_q) ? stable_inc : StabW'(1);
      stable_full = (stable_next == StabMax);
   end

   always_comb begin
      dwell_d     = dwell_q + DivW'(1);
      row_idx_d   = row_idx_q;
      acc_cnt_d   = acc_cnt_q;
      acc_code_d  = acc_code_q;
      prev_d      = prev_q;
      stable_d    = stable_q;
      key_code_d  = key_code_q;
      key_held_d  = key_held_q;
      key_valid_d = 1'b0;

      if (sample) begin
         dwell_d    = '0;
         row_idx_d  = row_idx_q + 2'd1;
         acc_cnt_d  = merged_cnt;
         acc_code_d = merged_code;
      end

      if (frame_end) begin
         acc_cnt_d  = 2'd0;
         acc_code_d = 4'h0;
         prev_d     = res;
         stable_d   = stable_next;
         // A held key (or a direct change to another key) must see an accepted NONE first.
         if (stable_full) begin
            if (res.kind == FR_SINGLE && !key_held_q) begin
               key_code_d  = res.code;
               key_held_d  = 1'b1;
               key_valid_d = 1'b1;
            end else if (res.kind == FR_NONE) begin
               key_held_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         dwell_q     <= '0;
         row_idx_q   <= 2'd0;
         acc_cnt_q   <= 2'd0;
         acc_code_q  <= 4'h0;
         prev_q      <= '{kind: FR_NONE, code: 4'h0};
         stable_q    <= '0;
         key_code_q  <= 4'h0;
         key_held_q  <= 1'b0;
         key_valid_q <= 1'b0;
      end else begin
         dwell_q     <= dwell_d;
         row_idx_q   <= row_idx_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_code_q  <= acc_code_d;
         prev_q      <= prev_d;
         stable_q    <= stable_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign keypad_row = row_drive(row_idx_q);
   assign key_code   = key_code_q;
   assign key_held   = key_held_q;
   assign key_valid  = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench: keypad modelled as a set of pressed key codes, frame-level reference model.
module tb_keypad_scan_debounce;

   localparam int SD = 8;
   localparam int DS = 3;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b0;
   logic [3:0]  keypad_col;
   logic [3:0]  keypad_row;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] mask = 16'h0;
   int          errors = 0;
   int          checks = 0;
   int          strobes = 0;

   int          layout [4][4] = '{'{7, 4, 1, 0}, '{8, 5, 2, 10}, '{9, 6, 3, 11}, '{12, 13, 14, 15}};
   logic [3:0]  rowv [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Reference model state: recent frame results (-1 none, 0..15 single, 16 multi).
   int          hist [$];
   logic        m_held;
   logic [3:0]  m_code;
   logic        m_valid;

   keypad_scan_debounce #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DS)
   ) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .keypad_col (keypad_col),
      .keypad_row (keypad_row),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_held   (key_held)
   );

   always #5 clk_in = ~clk_in;

   always_comb begin
      keypad_col = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         if (keypad_row == rowv[r]) begin
            for (int c = 0; c < 4; c++) begin
               if (mask[layout[r][c]]) keypad_col[c] = 1'b0;
            end
         end
      end
   end

   task automatic model_reset();
      hist.delete();
      m_held  = 1'b0;
      m_code  = 4'h0;
      m_valid = 1'b0;
   endtask

   task automatic model_frame(input logic [15:0] m);
      int res;
      int n;
      bit same;
      n   = $countones(m);
      res = (n == 0) ? -1 : 16;
      if (n == 1) begin
         for (int k = 0; k < 16; k++) if (m[k]) res = k;
      end
      hist.push_back(res);
      if (hist.size() > DS) void'(hist.pop_front());
      m_valid = 1'b0;
      if (hist.size() == DS) begin
         same = 1'b1;
         foreach (hist[j]) if (hist[j] != res) same = 1'b0;
         if (same) begin
            if (res >= 0 && res < 16 && !m_held) begin
               m_valid = 1'b1;
               m_held  = 1'b1;
               m_code  = 4'(res);
            end else if (res == -1) begin
               m_held = 1'b0;
            end
         end
      end
   endtask

   // Entered and left at the negedge of the first cycle of a frame.
   task automatic run_frame(input logic [15:0] m);
      checks += 4;
      if (key_valid !== m_valid) begin
         errors++;
         $display("FAIL frame_valid: got %b expected %b", key_valid, m_valid);
      end
      if (key_held !== m_held) begin
         errors++;
         $display("FAIL frame_held: got %b expected %b", key_held, m_held);
      end
      if (key_code !== m_code) begin
         errors++;
         $display("FAIL frame_code: got %h expected %h", key_code, m_code);
      end
      if (keypad_row !== 4'b1110) begin
         errors++;
         $display("FAIL frame_row0: got %b expected 1110", keypad_row);
      end
      if (key_valid === 1'b1) strobes++;
      mask = m;
      for (int i = 1; i < 4 * SD; i++) begin
         @(negedge clk_in);
         checks += 2;
         if (keypad_row !== rowv[i / SD]) begin
            errors++;
            $display("FAIL scan_row: cycle %0d got %b expected %b", i, keypad_row, rowv[i / SD]);
         end
         if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_valid: cycle %0d got %b expected 0", i, key_valid);
         end
      end
      @(negedge clk_in);
      model_frame(m);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      mask  = 16'h0;
      repeat (3) @(negedge clk_in);
      checks++;
      if ({keypad_row, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got row=%b code=%h valid=%b held=%b expected 1110/0/0/0",
                  keypad_row, key_code, key_valid, key_held);
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_idle();
      int s0 = strobes;
      repeat (3) run_frame(16'h0);
      checks++;
      if (strobes != s0 || key_code !== 4'h0) begin
         errors++;
         $display("FAIL idle: got strobes=%0d code=%h expected 0/0", strobes - s0, key_code);
      end
   endtask

   task automatic test_hold_release();
      int s0 = strobes;
      repeat (10) run_frame(16'h1 << 5);
      checks++;
      if (strobes - s0 != 1 || key_code !== 4'h5 || key_held !== 1'b1) begin
         errors++;
         $display("FAIL hold_key5: got strobes=%0d code=%h held=%b expected 1/5/1",
                  strobes - s0, key_code, key_held);
      end
      repeat (4) run_frame(16'h0);
   endtask

   task automatic test_toggle();
      int s0 = strobes;
      for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? (16'h1 << 5) : 16'h0);
      checks++;
      if (strobes != s0) begin
         errors++;
         $display("FAIL toggle_nostrobe: got strobes=%0d expected 0", strobes - s0);
      end
      repeat (4) run_frame(16'h1 << 5);
      checks++;
      if (strobes - s0 != 1) begin
         errors++;
         $display("FAIL toggle_stable: got strobes=%0d expected 1", strobes - s0);
      end
      repeat (4) run_frame(16'h0);
   endtask

   task automatic test_multi();
      int s0 = strobes;
      logic [3:0] code0 = m_code;
      repeat (6) run_frame((16'h1 << 1) | (16'h1 << 15));
      run_frame(16'h0);
      checks++;
      if (strobes != s0 || key_code !== code0) begin
         errors++;
         $display("FAIL multi: got strobes=%0d code=%h expected 0/%h", strobes - s0, key_code, code0);
      end
      repeat (3) run_frame(16'h0);
   endtask

   task automatic test_direct_change();
      int s0 = strobes;
      repeat (4) run_frame(16'h1 << 10);
      repeat (4) run_frame(16'h1 << 3);
      checks++;
      if (strobes - s0 != 1 || key_code !== 4'hA) begin
         errors++;
         $display("FAIL direct_change: got strobes=%0d code=%h expected 1/a", strobes - s0, key_code);
      end
      repeat (3) run_frame(16'h0);
      repeat (3) run_frame(16'h1 << 3);
      run_frame(16'h0);
      checks++;
      if (strobes - s0 != 2 || key_code !== 4'h3) begin
         errors++;
         $display("FAIL repress_3: got strobes=%0d code=%h expected 2/3", strobes - s0, key_code);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      int s0;
      repeat (4) run_frame(16'h1 << 9);
      k = $urandom_range(9, 30);
      mask = 16'h1 << 9;
      for (int i = 0; i < k; i++) @(negedge clk_in);
      reset = 1'b0;
      #1;
      checks++;
      if ({keypad_row, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: got row=%b code=%h valid=%b held=%b expected 1110/0/0/0",
                  keypad_row, key_code, key_valid, key_held);
      end
      @(negedge clk_in);
      reset = 1'b1;
      model_reset();
      s0 = strobes;
      repeat (3) run_frame(16'h1 << 9);
      checks++;
      if (strobes != s0) begin
         errors++;
         $display("FAIL reset_early_strobe: got strobes=%0d expected 0", strobes - s0);
      end
      run_frame(16'h1 << 9);
      checks++;
      if (strobes - s0 != 1 || key_code !== 4'h9) begin
         errors++;
         $display("FAIL reset_restrobe: got strobes=%0d code=%h expected 1/9", strobes - s0, key_code);
      end
      repeat (4) run_frame(16'h0);
   endtask

   task automatic test_random();
      logic [15:0] m;
      int kind;
      int a;
      int b;
      for (int seg = 0; seg < 25; seg++) begin
         kind = $urandom_range(0, 9);
         a    = $urandom_range(0, 15);
         b    = (a + $urandom_range(1, 15)) % 16;
         if (kind < 3) m = 16'h0;
         else if (kind < 9) m = 16'h1 << a;
         else m = (16'h1 << a) | (16'h1 << b);
         repeat ($urandom_range(1, 5)) run_frame(m);
      end
      run_frame(16'h0);
   endtask

   initial begin
      test_reset();
      test_idle();
      test_hold_release();
      test_toggle();
      test_multi();
      test_direct_change();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
